vga_timing_1024x768: RTL
========================

VGA_TIMING_1024X768 -- requirements
Module: vga_timing_1024x768

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk_pixel is the only clock, and rst_n is the reset.
REQ-002 Parameters (name, default, meaning):
- H_VISIBLE, 1024, active pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 160, horizontal back porch
- V_VISIBLE, 768, active lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 29, vertical back porch
- LOCK_HOLD, 16, consecutive qualified-lock cycles required before running
REQ-003 Ports (name, direction, width, meaning):
- clk_pixel, in, 1, 65 MHz pixel clock from the PLL CLKOS output
- rst_n, in, 1, asynchronous active-low reset
- locked, in, 1, PLL lock, asynchronous to clk_pixel
- hsync_n, out, 1, horizontal sync, active low
- vsync_n, out, 1, vertical sync, active low
- de, out, 1, display enable (visible pixel)
- x, out, 11, pixel column
- y, out, 10, pixel row
- frame_start, out, 1, one-cycle pulse at pixel (0,0)
- line_start, out, 1, one-cycle pulse at x=0 of each visible line
- running, out, 1, high when the timing generator is in state RUN

Function
REQ-004 locked SHALL pass through a 2-flop synchronizer; the synchronized signal is called locked_s.
REQ-005 FSM states SHALL be WAIT_LOCK and RUN.
- WAIT_LOCK: hold counter increments while locked_s=1 and clears when locked_s=0.
- WAIT_LOCK -> RUN when the hold counter reaches LOCK_HOLD-1 with locked_s=1.
REQ-006 In RUN, locked_s=0 SHALL force WAIT_LOCK on the next edge, clear the hold counter and the h/v counters, and deassert every output on the following cycle (sync outputs return to 1).
REQ-007 hcount SHALL run 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters = 1344, then wrap to 0. vcount SHALL increment on each hcount wrap and run 0..V_TOTAL-1 = 0..805, then wrap to 0.
REQ-008 On the first RUN cycle, hcount=0 and vcount=0.
REQ-009 All outputs SHALL be registered from the counters with exactly 1 cycle latency.
REQ-010 Output decoding, where h and v are the counter values one cycle earlier:
- de = (h < H_VISIBLE) and (v < V_VISIBLE)
- hsync_n = 0 for H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC, i.e. 1048..1183
- vsync_n = 0 for V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC, i.e. 771..776, for the full line
REQ-011 x SHALL equal h and y SHALL equal v (zero-extended) while de=1; x and y SHALL read 0 while de=0.
REQ-012 line_start SHALL be asserted when h=0 and v<V_VISIBLE. frame_start SHALL be asserted when h=0 and v=0. Each is asserted coincident with the de rising edge.
REQ-013 Counter widths SHALL be fixed at 11 bits (h) and 10 bits (v). Parameter sets whose totals overflow these widths are unsupported.
REQ-014 A locked glitch shorter than LOCK_HOLD cycles in WAIT_LOCK SHALL restart qualification from 0.

Reset
REQ-015 With rst_n=0 the module SHALL be in WAIT_LOCK with the synchronizer flops, hold counter and counters at 0; outputs SHALL be hsync_n=1, vsync_n=1, de=0, x=0, y=0, frame_start=0, line_start=0, running=0.
REQ-016 Reset deassertion SHALL NOT by itself start timing; lock qualification per REQ-005 is always required.

Structure
REQ-017 Timing constants (default totals 1344/806, sync windows) and the FSM state enum SHALL live in shared package video_timing_pkg.
REQ-018 The 2-flop synchronizer SHALL be sub-module sync_2ff. Counters, FSM and decode SHALL reside in vga_timing_1024x768.

Verification
REQ-019 Required directed scenarios (stimulus -> required response):
- Lock start: locked held at 1 after reset -> first frame_start exactly LOCK_HOLD+3 clk_pixel edges after the first edge sampling locked=1, and running=1 beforehand.
- Line geometry: in RUN, de high for 1024 consecutive cycles per line; line period 1344 cycles; hsync_n low for 136 cycles starting 24 cycles after de falls.
- Frame geometry: frame_start period 1,083,264 cycles; 768 line_start pulses per frame; vsync_n low for 6x1344 = 8064 cycles starting 3 lines after the last visible line.
- Lock loss: locked dropped mid-line (x=500, y=300) -> running=0 and de=0 within 4 cycles, hsync_n=vsync_n=1, x=y=0; restore locked -> new frame begins at (0,0) after requalification.
- Glitch: locked pulsed high for 10 cycles (less than LOCK_HOLD) then low -> running stays 0, no frame_start.
- Reset mid-frame: rst_n asserted at y=400 -> all outputs at REQ-015 values immediately (asynchronous); release with locked=1 -> requalify per the lock-start case.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared timing constants for the 1024x768 @ 60 Hz raster and the state
// type of the timing generator.
//
// Defaults: 1024+24+136+160 = 1344 clocks per line,
//           768+3+6+29 = 806 lines per frame.
// hsync is active over h = 1048..1183, vsync over v = 771..776.
// Counter widths are fixed: 11 bits horizontal, 10 bits vertical.
package video_timing_pkg;

  localparam int H_W = 11;
  localparam int V_W = 10;

  localparam int H_VISIBLE_DEF = 1024;
  localparam int H_FP_DEF      = 24;
  localparam int H_SYNC_DEF    = 136;
  localparam int H_BP_DEF      = 160;
  localparam int V_VISIBLE_DEF = 768;
  localparam int V_FP_DEF      = 3;
  localparam int V_SYNC_DEF    = 6;
  localparam int V_BP_DEF      = 29;

  localparam int H_TOTAL_DEF     = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF     = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HSYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int HSYNC_END_DEF   = HSYNC_START_DEF + H_SYNC_DEF;
  localparam int VSYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int VSYNC_END_DEF   = VSYNC_START_DEF + V_SYNC_DEF;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } vt_state_e;

  // Half-open window test [lo, hi) used for the sync pulse decode.
  function automatic logic in_window(input logic [H_W-1:0] val,
                                     input logic [H_W-1:0] lo,
                                     input logic [H_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
//
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops
//   d     - asynchronous input level
//   q     - level synchronized to clk (2 cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_1024x768.sv
// vga_timing_1024x768
// Raster timing generator for 1024x768. Waits for the pixel PLL to report
// a stable lock for LOCK_HOLD consecutive cycles, then free-runs the h/v
// counters and decodes sync, display enable and coordinates from them.
// Losing lock drops back to qualification and idles every output.
//
// Ports:
//   clk_pixel   - 65 MHz pixel clock
//   rst_n       - asynchronous active-low reset
//   locked      - PLL lock, asynchronous to clk_pixel
//   hsync_n     - horizontal sync, active low
//   vsync_n     - vertical sync, active low
//   de          - display enable, high on visible pixels
//   x, y        - pixel column / row while de=1, otherwise 0
//   frame_start - one-cycle pulse at pixel (0,0)
//   line_start  - one-cycle pulse at x=0 of every visible line
//   running     - high while the generator is in RUN
module vga_timing_1024x768
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int LOCK_HOLD = 16
) (
  input  logic           clk_pixel,
  input  logic           rst_n,
  input  logic           locked,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           frame_start,
  output logic           line_start,
  output logic           running
);

  localparam logic [H_W-1:0] H_VIS  = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] H_LAST = H_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_VISIBLE + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_VIS  = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  // Vertical window bounds widened to H_W so one window function serves both.
  localparam logic [H_W-1:0] VS_BEG = H_W'(V_VISIBLE + V_FP);
  localparam logic [H_W-1:0] VS_END = H_W'(V_VISIBLE + V_FP + V_SYNC);

  localparam int                 HOLD_W    = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  logic              locked_s;
  vt_state_e         state;
  logic [HOLD_W-1:0] hold;
  logic [H_W-1:0]    h_p0;
  logic [V_W-1:0]    v_p0;
  logic              vis_p0;
  logic              h_last_p0;
  logic              v_last_p0;

  sync_2ff u_lock_sync (
    .clk   (clk_pixel),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  assign h_last_p0 = (h_p0 == H_LAST);
  assign v_last_p0 = (v_p0 == V_LAST);
  assign vis_p0    = (h_p0 < H_VIS) && (v_p0 < V_VIS);

  // Stage 0: lock qualification FSM and raster counters. Counters sit at
  // (0,0) throughout WAIT_LOCK so the first RUN cycle is pixel (0,0).
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_LOCK;
      hold    <= '0;
      h_p0    <= '0;
      v_p0    <= '0;
      running <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          h_p0 <= '0;
          v_p0 <= '0;
          if (!locked_s) begin
            hold <= '0;
          end else if (hold == HOLD_LAST) begin
            state   <= RUN;
            running <= 1'b1;
            hold    <= '0;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state   <= WAIT_LOCK;
            running <= 1'b0;
            hold    <= '0;
            h_p0    <= '0;
            v_p0    <= '0;
          end else begin
            h_p0 <= h_last_p0 ? '0 : h_p0 + H_W'(1);
            if (h_last_p0) begin
              v_p0 <= v_last_p0 ? '0 : v_p0 + V_W'(1);
            end
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: registered decode of the counters. Outside RUN everything
  // idles, which delays the lock-loss idle by one cycle after running falls.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (state == RUN) begin
      hsync_n     <= !in_window(h_p0, HS_BEG, HS_END);
      vsync_n     <= !in_window(H_W'(v_p0), VS_BEG, VS_END);
      de          <= vis_p0;
      x           <= vis_p0 ? h_p0 : '0;
      y           <= vis_p0 ? v_p0 : '0;
      frame_start <= (h_p0 == '0) && (v_p0 == '0);
      line_start  <= (h_p0 == '0) && (v_p0 < V_VIS);
    end else begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

endmodule
